// File: rtl/ram_cmd_arbiter_pkg.sv
// Shared opcodes and FSM state type for the RAM command arbiter.
package ram_ctrl_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_RD,
        RESP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_cmd_arbiter_if.sv
// Client-side request/ack bus plus the RAM-side command/response bus.
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees ack high for one cycle; it drops req at the edge ending that cycle.
interface ram_cmd_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_SIZE = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           we;
    logic [NUM_REQ*ADDR_SIZE-1:0] addr;
    logic [NUM_REQ*8-1:0]         wdata;
    logic [NUM_REQ-1:0]           ack;
    logic [7:0]                   rdata;
    logic                         err;
    logic [9:0]                   ram_din;
    logic                         ram_rx_valid;
    logic [7:0]                   ram_dout;
    logic                         ram_tx_valid;

    modport master (
        output req, we, addr, wdata, ram_dout, ram_tx_valid,
        input  ack, rdata, err, ram_din, ram_rx_valid
    );

    modport slave (
        input  req, we, addr, wdata, ram_dout, ram_tx_valid,
        output ack, rdata, err, ram_din, ram_rx_valid
    );
endinterface

// File: rtl/ram_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module rr_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares one SPI-style RAM among NUM_REQ requesters, turning each request
// into an address word plus data word on ram_din/ram_rx_valid.
module ram_cmd_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_cmd_arbiter_if.slave  bus,
    output state_t            dbg_state
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0]     win_oh_q, win_oh_d;
    logic                   we_q, we_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [9:0]             din_q, din_d;
    logic                   rx_valid_q, rx_valid_d;

    logic [NUM_REQ-1:0]     gnt_oh;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [7:0]             sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign sel_addr  = bus.addr[int'(gnt_idx)*ADDR_SIZE +: ADDR_SIZE];
    assign sel_wdata = bus.wdata[int'(gnt_idx)*8 +: 8];

    // Outputs are registered, so each state prepares the word seen in the next one.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_idx_d  = win_idx_q;
        win_oh_d   = win_oh_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        din_d      = din_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    win_idx_d  = gnt_idx;
                    win_oh_d   = gnt_oh;
                    we_d       = bus.we[gnt_idx];
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    rdata_d    = '0;
                    err_d      = 1'b0;
                    din_d      = {bus.we[gnt_idx] ? OP_WR_ADDR : OP_RD_ADDR, 8'(sel_addr)};
                    rx_valid_d = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                din_d      = we_q ? {OP_WR_DATA, wdata_q} : {OP_RD_DATA, 8'h00};
                rx_valid_d = 1'b1;
                state_d    = DATA;
            end
            DATA: begin
                cnt_d = '0;
                if (we_q) begin
                    ack_d   = win_oh_q;
                    state_d = RESP;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + CW'(1);
                // Data arriving on the timeout cycle still counts as a good read.
                if (bus.ram_tx_valid) begin
                    rdata_d = bus.ram_dout;
                    err_d   = 1'b0;
                    ack_d   = win_oh_q;
                    state_d = RESP;
                end else if (cnt_d == CW'(RD_TIMEOUT)) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    ack_d   = win_oh_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = win_idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NUM_REQ - 1);
            win_idx_q  <= '0;
            win_oh_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            din_q      <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_idx_q  <= win_idx_d;
            win_oh_q   <= win_oh_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            din_q      <= din_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.rdata        = rdata_q;
    assign bus.err          = err_q;
    assign bus.ram_din      = din_q;
    assign bus.ram_rx_valid = rx_valid_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: reset, write, read, contention, timeouts.
module tb_ram_cmd_arbiter;
    import ram_ctrl_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_SIZE  = 8;
    localparam int RD_TIMEOUT = 15;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     errors;
    int     checks;
    int     lat;
    int     w;

    ram_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_SIZE(ADDR_SIZE)) bus ();

    ram_cmd_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_SIZE  (ADDR_SIZE),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ticks until ack is seen; lat = cycles from the sampling edge, -1 if the budget runs out.
    task automatic wait_ack(input int budget, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            if (!done) begin
                tick();
                if (bus.ack != '0) begin
                    done   = 1'b1;
                    cycles = i;
                end
            end
        end
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        bus.req          = '0;
        bus.we           = '0;
        bus.addr         = '0;
        bus.wdata        = '0;
        bus.ram_dout     = '0;
        bus.ram_tx_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 32'(bus.ack), 32'h0);
        chk("reset_rdata", 32'(bus.rdata), 32'h0);
        chk("reset_err", 32'(bus.err), 32'h0);
        chk("reset_din", 32'(bus.ram_din), 32'h0);
        chk("reset_rx_valid", 32'(bus.ram_rx_valid), 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();

        // Reset asserted while the data word is on the bus.
        bus.req        = 2'b01;
        bus.we         = 2'b01;
        bus.addr[7:0]  = 8'h77;
        bus.wdata[7:0] = 8'h11;
        tick();
        tick();
        chk("midrst_pre_rx", 32'(bus.ram_rx_valid), 32'h1);
        chk("midrst_pre_din", 32'(bus.ram_din), 32'h111);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rx", 32'(bus.ram_rx_valid), 32'h0);
        chk("midrst_ack", 32'(bus.ack), 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        wait_ack(10, lat);
        chk("midrst_lat", 32'(lat), 32'd3);
        chk("midrst_ack0", 32'(bus.ack), 32'h1);
        bus.req = '0;
        tick();

        // Single write from requester 0.
        bus.req        = 2'b01;
        bus.we         = 2'b01;
        bus.addr[7:0]  = 8'h3C;
        bus.wdata[7:0] = 8'hA5;
        tick();
        chk("wr_addr_rx", 32'(bus.ram_rx_valid), 32'h1);
        chk("wr_addr_din", 32'(bus.ram_din), 32'h03C);
        tick();
        chk("wr_data_rx", 32'(bus.ram_rx_valid), 32'h1);
        chk("wr_data_din", 32'(bus.ram_din), 32'h1A5);
        tick();
        chk("wr_ack", 32'(bus.ack), 32'h1);
        chk("wr_resp_rx", 32'(bus.ram_rx_valid), 32'h0);
        bus.req = '0;
        tick();
        chk("wr_idle_ack", 32'(bus.ack), 32'h0);

        // Single read from requester 1, RAM answers one cycle after the data word.
        bus.req        = 2'b10;
        bus.we         = 2'b00;
        bus.addr[15:8] = 8'h3C;
        tick();
        chk("rd_addr_din", 32'(bus.ram_din), 32'h23C);
        tick();
        chk("rd_data_din", 32'(bus.ram_din), 32'h300);
        chk("rd_data_rx", 32'(bus.ram_rx_valid), 32'h1);
        tick();
        chk("rd_wait_ack", 32'(bus.ack), 32'h0);
        chk("rd_wait_rx", 32'(bus.ram_rx_valid), 32'h0);
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'hA5;
        tick();
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = 8'h00;
        chk("rd_ack", 32'(bus.ack), 32'h2);
        chk("rd_rdata", 32'(bus.rdata), 32'hA5);
        chk("rd_err", 32'(bus.err), 32'h0);
        bus.req = '0;
        tick();

        // Both requesters writing: grants alternate and word pairs stay contiguous.
        bus.we          = 2'b11;
        bus.addr[7:0]   = 8'h11;
        bus.wdata[7:0]  = 8'hB1;
        bus.addr[15:8]  = 8'h22;
        bus.wdata[15:8] = 8'hB2;
        bus.req         = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = k % 2;
            tick();
            chk("cont_addr_din", 32'(bus.ram_din), (w == 0) ? 32'h011 : 32'h022);
            chk("cont_addr_rx", 32'(bus.ram_rx_valid), 32'h1);
            tick();
            chk("cont_data_din", 32'(bus.ram_din), (w == 0) ? 32'h1B1 : 32'h1B2);
            chk("cont_data_rx", 32'(bus.ram_rx_valid), 32'h1);
            tick();
            chk("cont_ack", 32'(bus.ack), (w == 0) ? 32'h1 : 32'h2);
            chk("cont_resp_rx", 32'(bus.ram_rx_valid), 32'h0);
            if (k == 3) bus.req = '0;
            else        bus.req[w] = 1'b0;
            tick();
            if (k < 3) bus.req[w] = 1'b1;
        end
        tick();

        // Read that never gets tx_valid.
        bus.req       = 2'b01;
        bus.we        = 2'b00;
        bus.addr[7:0] = 8'h40;
        wait_ack(40, lat);
        chk("to_lat", 32'(lat), 32'(3 + RD_TIMEOUT));
        chk("to_ack", 32'(bus.ack), 32'h1);
        chk("to_err", 32'(bus.err), 32'h1);
        chk("to_rdata", 32'(bus.rdata), 32'h00);
        bus.req = '0;
        tick();

        // tx_valid lands on the same cycle the timeout would fire.
        bus.req        = 2'b10;
        bus.we         = 2'b00;
        bus.addr[15:8] = 8'h55;
        for (int i = 0; i < 2 + RD_TIMEOUT; i++) tick();
        chk("tie_pre_ack", 32'(bus.ack), 32'h0);
        bus.ram_tx_valid = 1'b1;
        bus.ram_dout     = 8'h5A;
        tick();
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = 8'h00;
        chk("tie_ack", 32'(bus.ack), 32'h2);
        chk("tie_rdata", 32'(bus.rdata), 32'h5A);
        chk("tie_err", 32'(bus.err), 32'h0);
        bus.req = '0;
        tick();

        // Normal write after the timeout paths.
        bus.req        = 2'b01;
        bus.we         = 2'b01;
        bus.addr[7:0]  = 8'h9A;
        bus.wdata[7:0] = 8'h3E;
        tick();
        chk("post_addr_din", 32'(bus.ram_din), 32'h09A);
        tick();
        chk("post_data_din", 32'(bus.ram_din), 32'h13E);
        tick();
        chk("post_ack", 32'(bus.ack), 32'h1);
        chk("post_err", 32'(bus.err), 32'h0);
        bus.req = '0;
        tick();
        chk("post_idle_state", 32'(dbg_state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
